layer_sequencer: RTL

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
//   Steps a shared neuron datapath through every output neuron of one layer.
//   For each neuron it strobes neuron_go, waits for neuron_done, captures the
//   raw result, stores a shifted and saturated activation into layer_out, and
//   tracks the neuron with the largest raw result (reported as class_idx).
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   layer_go      start request, sampled only in IDLE
//   busy          high in every state except IDLE
//   layer_done    one-cycle completion pulse (DONE state)
//   neuron_go     one-cycle start strobe to the datapath (START state)
//   neuron_done   datapath completion strobe, sampled only in WAIT
//   neuron_result signed datapath result, valid with neuron_done
//   neuron_idx    active neuron (weight row / bias select)
//   layer_out     activation buffer, neuron k at [(k+1)*WIDTH_ACT-1 -: WIDTH_ACT]
//   class_idx     index of the largest raw result of the last layer
//
// Build option
//   LAYER_SEQUENCER_RELU_EN  when defined, activations clamp to the unsigned
//                            range [0, 2^WIDTH_ACT-1]; otherwise they clamp to
//                            the signed two's-complement range.
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for layer_go
// START  | neuron_go strobe for neuron_idx
// WAIT   | waiting for neuron_done; result captured on that cycle
// STORE  | write activation, update running max, advance or finish
// DONE   | layer_done pulse, class_idx published
// ---------------------------------------------------------------------------
module layer_sequencer #(
  parameter int OUT_SIZE  = 32,
  parameter int WIDTH_OUT = 24,
  parameter int WIDTH_ACT = 8,
  parameter int SHIFT     = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              layer_go,
  output logic                              busy,
  output logic                              layer_done,
  output logic                              neuron_go,
  input  logic                              neuron_done,
  input  logic signed [WIDTH_OUT-1:0]       neuron_result,
  output logic [$clog2(OUT_SIZE)-1:0]       neuron_idx,
  output logic [OUT_SIZE*WIDTH_ACT-1:0]     layer_out,
  output logic [$clog2(OUT_SIZE)-1:0]       class_idx
);

  localparam int IW = $clog2(OUT_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(OUT_SIZE - 1);

`ifdef LAYER_SEQUENCER_RELU_EN
  localparam logic signed [WIDTH_OUT-1:0] ACT_MAX = WIDTH_OUT'((1 << WIDTH_ACT) - 1);
`else
  localparam logic signed [WIDTH_OUT-1:0] ACT_MAX = WIDTH_OUT'((1 << (WIDTH_ACT - 1)) - 1);
  localparam logic signed [WIDTH_OUT-1:0] ACT_MIN = WIDTH_OUT'(-(1 << (WIDTH_ACT - 1)));
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [IW-1:0]                 cand_q, cand_d;
  logic [IW-1:0]                 class_q, class_d;
  logic signed [WIDTH_OUT-1:0]   capture_q, capture_d;
  logic signed [WIDTH_OUT-1:0]   max_q, max_d;
  logic [OUT_SIZE*WIDTH_ACT-1:0] layer_out_q, layer_out_d;
  logic signed [WIDTH_OUT-1:0]   shifted;
  logic [WIDTH_ACT-1:0]          act;

  // Shift then saturate the captured result into an activation.
  always_comb begin
    shifted = capture_q >>> SHIFT;
    act     = shifted[WIDTH_ACT-1:0];
`ifdef LAYER_SEQUENCER_RELU_EN
    if (shifted[WIDTH_OUT-1]) begin
      act = '0;
    end else if (shifted > ACT_MAX) begin
      act = '1;
    end
`else
    if (shifted > ACT_MAX) begin
      act = {1'b0, {(WIDTH_ACT-1){1'b1}}};
    end else if (shifted < ACT_MIN) begin
      act = {1'b1, {(WIDTH_ACT-1){1'b0}}};
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cand_d      = cand_q;
    class_d     = class_q;
    capture_d   = capture_q;
    max_d       = max_q;
    layer_out_d = layer_out_q;

    case (state_q)
      S_IDLE: begin
        if (layer_go) begin
          state_d = S_START;
          idx_d   = '0;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (neuron_done) begin
          capture_d = neuron_result;
          state_d   = S_STORE;
        end
      end
      S_STORE: begin
        layer_out_d[idx_q*WIDTH_ACT +: WIDTH_ACT] = act;
        // Strict compare: on a tie the lower index stays the candidate.
        if (idx_q == '0) begin
          max_d  = capture_q;
          cand_d = '0;
        end else if (capture_q > max_q) begin
          max_d  = capture_q;
          cand_d = idx_q;
        end
        if (idx_q < LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        class_d = cand_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cand_q      <= '0;
      class_q     <= '0;
      capture_q   <= '0;
      max_q       <= '0;
      layer_out_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cand_q      <= cand_d;
      class_q     <= class_d;
      capture_q   <= capture_d;
      max_q       <= max_d;
      layer_out_q <= layer_out_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign layer_done = (state_q == S_DONE);
  assign neuron_go  = (state_q == S_START);
  assign neuron_idx = idx_q;
  assign layer_out  = layer_out_q;
  // The new winner is already visible during the DONE cycle itself.
  assign class_idx  = (state_q == S_DONE) ? cand_q : class_q;

endmodule
